// File: rtl/uart_pkg.sv
// Shared definitions for the feather UART demos: FSM states, ASCII constants and
// the nibble-to-hex-character helper.
package uart_pkg;

    typedef enum logic [2:0] {IDLE, PREFIX, HEX, CR, LF} state_t;

    localparam logic [7:0] ASCII_CR   = 8'h0D;
    localparam logic [7:0] ASCII_LF   = 8'h0A;
    localparam int         PREFIX_LEN = 7;
    localparam logic [8*PREFIX_LEN-1:0] MSG_PREFIX = "ICE40 #";

    function automatic logic [7:0] hex2ascii(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h41 + {4'h0, n} - 8'd10);
    endfunction

endpackage

// File: rtl/period_timer.sv
// Free-running period timer: one-cycle tick every CLK_HZ/1000*PERIOD_MS cycles.
module period_timer #(
    parameter int CLK_HZ    = 12_000_000,
    parameter int PERIOD_MS = 100
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int PERIOD_CYCLES = CLK_HZ / 1000 * PERIOD_MS;
    localparam int W             = $clog2(PERIOD_CYCLES);

    logic [W-1:0] timer;

    assign tick = (timer == W'(PERIOD_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (rst || tick)
            timer <= '0;
        else
            timer <= timer + W'(1);
    end

endmodule

// File: rtl/uart_msg_gen.sv
// Streams "ICE40 #hhhh\r\n" to uart_tx over valid/ready, hhhh = completed-message count.
// Messages start on start or the periodic tick; one trigger may queue while busy.
module uart_msg_gen
    import uart_pkg::*;
#(
    parameter int CLK_HZ    = 12_000_000,
    parameter int PERIOD_MS = 100,
    parameter bit AUTO      = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        busy,
    output logic [15:0] msg_count
);

    state_t      state, state_n;
    logic [2:0]  idx, idx_n;
    logic [1:0]  nib, nib_n;
    logic [15:0] snap, snap_n;
    logic        pending, pend_n;
    logic        done;
    logic [15:0] done_cnt;
    logic [7:0]  prefix_char;
    logic        tick, trig, xfer;

    generate
        if (AUTO) begin : g_timer
            period_timer #(.CLK_HZ(CLK_HZ), .PERIOD_MS(PERIOD_MS)) u_timer (
                .clk  (clk),
                .rst  (rst),
                .tick (tick)
            );
        end else begin : g_no_timer
            assign tick = 1'b0;
        end
    endgenerate

    assign trig      = start | tick;
    assign tx_valid  = (state != IDLE);
    assign busy      = tx_valid;
    assign xfer      = tx_valid & tx_ready;
    assign msg_count = done_cnt;

    always_comb begin
        prefix_char = 8'h00;
        case (idx)
            3'd0:    prefix_char = MSG_PREFIX[55:48];
            3'd1:    prefix_char = MSG_PREFIX[47:40];
            3'd2:    prefix_char = MSG_PREFIX[39:32];
            3'd3:    prefix_char = MSG_PREFIX[31:24];
            3'd4:    prefix_char = MSG_PREFIX[23:16];
            3'd5:    prefix_char = MSG_PREFIX[15:8];
            3'd6:    prefix_char = MSG_PREFIX[7:0];
            default: prefix_char = 8'h00;
        endcase
    end

    // Output byte is a pure function of registered state, so it is stable while stalled.
    always_comb begin
        tx_data = 8'h00;
        case (state)
            PREFIX:  tx_data = prefix_char;
            HEX:     tx_data = hex2ascii(snap[{nib, 2'b00} +: 4]);
            CR:      tx_data = ASCII_CR;
            LF:      tx_data = ASCII_LF;
            default: tx_data = 8'h00;
        endcase
    end

    always_comb begin
        state_n = state;
        idx_n   = idx;
        nib_n   = nib;
        snap_n  = snap;
        pend_n  = pending;
        done    = 1'b0;
        if (state == IDLE) begin
            if (trig || pending) begin
                state_n = PREFIX;
                idx_n   = '0;
                snap_n  = done_cnt;
                pend_n  = 1'b0;
            end
        end else if (trig) begin
            pend_n = 1'b1;
        end
        case (state)
            PREFIX: if (xfer) begin
                if (idx == 3'(PREFIX_LEN - 1)) begin
                    state_n = HEX;
                    nib_n   = 2'd3;
                end else begin
                    idx_n = idx + 3'd1;
                end
            end
            HEX: if (xfer) begin
                if (nib == 2'd0) state_n = CR;
                else             nib_n   = nib - 2'd1;
            end
            CR: if (xfer) state_n = LF;
            LF: if (xfer) begin
                state_n = IDLE;
                done    = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            idx      <= '0;
            nib      <= '0;
            snap     <= '0;
            pending  <= 1'b0;
            done_cnt <= '0;
        end else begin
            state    <= state_n;
            idx      <= idx_n;
            nib      <= nib_n;
            snap     <= snap_n;
            pending  <= pend_n;
            done_cnt <= done_cnt + {15'd0, done};
        end
    end

endmodule

// File: tb/tb_uart_msg_gen.sv
// Bench for uart_msg_gen: a string-level message model checked every cycle, plus
// directed scenarios with literal byte expectations (manual triggers, backpressure, wrap, auto period).
module tb_uart_msg_gen;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, start, tx_ready;
    logic [7:0]  tx_data;
    logic        tx_valid, busy;
    logic [15:0] msg_count;

    logic        rst1, start1, tx_ready1;
    logic [7:0]  data1;
    logic        valid1, busy1;
    logic [15:0] cnt1;

    uart_msg_gen #(.CLK_HZ(12_000_000), .PERIOD_MS(100), .AUTO(1'b0)) dut0 (
        .clk(clk), .rst(rst), .start(start), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .busy(busy), .msg_count(msg_count)
    );

    uart_msg_gen #(.CLK_HZ(12_000_000), .PERIOD_MS(1), .AUTO(1'b1)) dut1 (
        .clk(clk), .rst(rst1), .start(start1), .tx_data(data1), .tx_valid(valid1),
        .tx_ready(tx_ready1), .busy(busy1), .msg_count(cnt1)
    );

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Model: current message is the text for m_cnt; m_pos is the next byte expected.
    logic [15:0] m_cnt = '0;
    int          m_pos = 0;
    int          m_msgs = 0;
    logic        stalled = 1'b0;
    logic [7:0]  st_data = '0;
    logic        prev_valid = 1'b0;
    int          lf_cyc = 0;
    int          gap = 0;
    logic [7:0]  rx_log[$];

    always @(negedge clk) begin
        string      s;
        logic [7:0] e;
        if (rst) begin
            m_cnt      = '0;
            m_pos      = 0;
            stalled    = 1'b0;
            prev_valid = 1'b0;
        end else begin
            s = $sformatf("ICE40 #%h", m_cnt);
            s = s.toupper();
            if (m_pos < 11)       e = s[m_pos];
            else if (m_pos == 11) e = 8'h0D;
            else                  e = 8'h0A;
            if (tx_valid) chk("stream_byte", tx_data, e);
            chk("busy_eq_valid", busy, tx_valid);
            chk("msg_count", msg_count, m_cnt);
            if (stalled) chk("stall_hold", {tx_valid, tx_data}, {1'b1, st_data});
            stalled = tx_valid && !tx_ready;
            st_data = tx_data;
            if (tx_valid && !prev_valid) gap = cyc - lf_cyc;
            prev_valid = tx_valid;
            if (tx_valid && tx_ready) begin
                rx_log.push_back(tx_data);
                m_pos++;
                if (m_pos == 13) begin
                    m_pos = 0;
                    m_cnt = m_cnt + 16'd1;
                    m_msgs++;
                    lf_cyc = cyc;
                end
            end
        end
    end

    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic wait_msgs(input int target, input int budget, input bit rnd);
        int n = 0;
        while (m_msgs < target && n < budget) begin
            @(posedge clk); #1;
            if (rnd) tx_ready = ($urandom_range(0, 99) < 30);
            n++;
        end
        chk("msg_done_in_budget", m_msgs, target);
        tx_ready = 1'b1;
    endtask

    task automatic chk_digits(input string name, input int off, input logic [31:0] exp32);
        if (rx_log.size() < off + 4) begin
            chk({name, "_len"}, rx_log.size(), off + 4);
        end else begin
            for (int i = 0; i < 4; i++)
                chk(name, rx_log[off + i], exp32[31 - 8*i -: 8]);
        end
    endtask

    task automatic force_count(input logic [15:0] v);
        @(posedge clk); #1;
        force dut0.done_cnt = v;
        m_cnt = v;
        @(posedge clk); #1;
        release dut0.done_cnt;
    endtask

    logic [7:0] exp1 [13] = '{8'h49, 8'h43, 8'h45, 8'h34, 8'h30, 8'h20, 8'h23,
                              8'h30, 8'h30, 8'h30, 8'h30, 8'h0D, 8'h0A};

    initial begin
        int base, n, r1, r2, seen;
        logic pv;
        rst = 1'b1; start = 1'b0; tx_ready = 1'b1;
        rst1 = 1'b1; start1 = 1'b0; tx_ready1 = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", tx_valid, 1'b0);
        chk("rst_data", tx_data, 8'h00);
        chk("rst_busy", busy, 1'b0);
        chk("rst_count", msg_count, 16'h0000);
        rst = 1'b0;

        // 1: single message, ready always high
        rx_log.delete();
        pulse_start();
        chk("latency_valid", tx_valid, 1'b1);
        chk("latency_data", tx_data, 8'h49);
        wait_msgs(1, 100, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        chk("t1_len", rx_log.size(), 13);
        for (int i = 0; i < 13 && i < rx_log.size(); i++) chk("t1_byte", rx_log[i], exp1[i]);
        chk("t1_count", msg_count, 16'd1);
        chk("t1_busy", busy, 1'b0);

        // 2: same message after reset, random backpressure
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        chk("t2_rst_count", msg_count, 16'd0);
        rx_log.delete();
        base = m_msgs;
        pulse_start();
        wait_msgs(base + 1, 600, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        chk("t2_len", rx_log.size(), 13);
        for (int i = 0; i < 13 && i < rx_log.size(); i++) chk("t2_byte", rx_log[i], exp1[i]);

        // 3: count 00AE then 00AF
        force_count(16'h00AE);
        rx_log.delete();
        base = m_msgs;
        pulse_start();
        wait_msgs(base + 1, 100, 1'b0);
        pulse_start();
        wait_msgs(base + 2, 100, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        chk_digits("t3_00AE", 7, 32'h30304145);
        chk_digits("t3_00AF", 20, 32'h30304146);
        chk("t3_count", msg_count, 16'h00B0);

        // 4: wrap FFFF -> 0000
        force_count(16'hFFFF);
        rx_log.delete();
        base = m_msgs;
        pulse_start();
        wait_msgs(base + 1, 100, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        chk("t4_wrap_count", msg_count, 16'h0000);
        pulse_start();
        wait_msgs(base + 2, 100, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        chk_digits("t4_FFFF", 7, 32'h46464646);
        chk_digits("t4_0000", 20, 32'h30303030);
        chk("t4_count", msg_count, 16'h0001);

        // 5: second start 3 cycles after the first queues exactly one more message
        base = m_msgs;
        pulse_start();
        repeat (2) @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        wait_msgs(base + 2, 200, 1'b0);
        chk("t5_gap", gap, 2);
        repeat (40) @(posedge clk);
        #1;
        chk("t5_msgs", m_msgs, base + 2);
        chk("t5_idle", tx_valid, 1'b0);

        // 6: auto trigger every 12000 cycles, then reset mid-HEX
        @(posedge clk); #1 rst1 = 1'b0;
        n = 0; r1 = 0; r2 = 0; pv = 1'b0;
        while (r2 == 0 && n < 30000) begin
            @(posedge clk); #1;
            n++;
            if (valid1 && !pv) begin
                if (r1 == 0) r1 = n;
                else         r2 = n;
            end
            pv = valid1;
        end
        chk("t6_first_start", r1, 12000);
        chk("t6_period", r2 - r1, 12000);
        chk("t6_count", cnt1, 16'd1);
        repeat (7) @(posedge clk);
        #1;
        chk("t6_in_hex", {valid1, data1}, {1'b1, 8'h30});
        rst1 = 1'b1;
        @(posedge clk); #1;
        chk("t6_rst_valid", valid1, 1'b0);
        chk("t6_rst_count", cnt1, 16'd0);
        chk("t6_rst_busy", busy1, 1'b0);
        chk("t6_rst_data", data1, 8'h00);
        rst1 = 1'b0;
        seen = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (valid1) seen++;
        end
        chk("t6_no_lf", seen, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
